// File: rtl/game_timer.sv
// game_timer: prescaled game clock with pause/quiz timeout and freeze FSM
module game_timer #(
  parameter int TICK_CYCLES = 500000000,
  parameter logic [7:0] LIMIT = 8'd96,
  parameter logic [3:0] QUIZ_LIMIT = 4'd12
) (
  input  logic       board_clk,
  input  logic       Reset,
  input  logic       clr,
  input  logic       start,
  input  logic       pause,
  input  logic       freeze,
  output logic       tick,
  output logic [7:0] count,
  output logic [3:0] quiz_ticks,
  output logic       quiz_timeout,
  output logic       expired,
  output logic [1:0] state
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, FROZEN} st_t;
  st_t st, ns;
  logic [28:0] psc;
  logic active;
  logic [7:0] count_n;
  assign state = st;
  assign active = st == RUN || st == PAUSED;
  assign tick = active && psc == 29'(TICK_CYCLES - 1);
  assign count_n = (st == RUN && tick && count != LIMIT) ? count + 8'd1 : count;
  always_comb
    ns = clr ? IDLE :
         (freeze && active) ? FROZEN :
         st == IDLE ? (start ? RUN : IDLE) :
         st == RUN ? (count == LIMIT ? FROZEN : pause ? PAUSED : RUN) :
         st == PAUSED ? (pause ? PAUSED : RUN) : FROZEN;
  always_ff @(posedge board_clk or posedge Reset)
    if (Reset) begin
      st <= IDLE;
      psc <= '0;
      count <= '0;
      expired <= 1'b0;
      quiz_ticks <= '0;
      quiz_timeout <= 1'b0;
    end else begin
      st <= ns;
      // prescaler only keeps running while staying within RUN/PAUSED
      psc <= (active && (ns == RUN || ns == PAUSED)) ? (tick ? '0 : psc + 29'd1) : '0;
      count <= clr ? '0 : count_n;
      expired <= !clr && count_n == LIMIT;
      quiz_ticks <= (clr || (ns == PAUSED && st != PAUSED)) ? '0 :
                    (st == PAUSED && tick && quiz_ticks != QUIZ_LIMIT) ? quiz_ticks + 4'd1 : quiz_ticks;
      quiz_timeout <= !clr && st == PAUSED && tick && quiz_ticks == QUIZ_LIMIT - 4'd1;
    end
endmodule

// File: tb/tb_game_timer.sv
// tb_game_timer: directed checks of game_timer with TICK_CYCLES=4, LIMIT=5, QUIZ_LIMIT=3
module tb_game_timer;
  logic board_clk = 0, Reset = 1, clr = 0, start = 0, pause = 0, freeze = 0;
  logic tick, quiz_timeout, expired;
  logic [7:0] count;
  logic [3:0] quiz_ticks;
  logic [1:0] state;
  int checks = 0, errors = 0;
  game_timer #(.TICK_CYCLES(4), .LIMIT(8'd5), .QUIZ_LIMIT(4'd3)) dut (
    .board_clk(board_clk), .Reset(Reset), .clr(clr), .start(start), .pause(pause),
    .freeze(freeze), .tick(tick), .count(count), .quiz_ticks(quiz_ticks),
    .quiz_timeout(quiz_timeout), .expired(expired), .state(state)
  );
  always #5 board_clk = ~board_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge board_clk);
    #1;
  endtask
  task automatic all_zero(input string tag);
    check({tag, "_state"}, 32'(state), 0);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_qt"}, 32'(quiz_ticks), 0);
    check({tag, "_exp"}, 32'(expired), 0);
    check({tag, "_tick"}, 32'(tick), 0);
    check({tag, "_qto"}, 32'(quiz_timeout), 0);
  endtask
  initial begin
    step(2);
    all_zero("reset");
    Reset = 0;
    step(2);
    check("idle_wait", 32'(state), 0);
    // full run to expiry
    start = 1; step(1); start = 0;
    check("run_entry", 32'(state), 1);
    step(3);
    check("first_tick", 32'(tick), 1);
    check("first_tick_cnt", 32'(count), 0);
    step(1);
    check("cnt1", 32'(count), 1);
    check("tick_low", 32'(tick), 0);
    for (int k = 2; k <= 5; k++) begin
      step(4);
      check($sformatf("cnt%0d", k), 32'(count), 32'(k));
    end
    check("expired", 32'(expired), 1);
    check("state_run_at_limit", 32'(state), 1);
    step(1);
    check("frozen", 32'(state), 3);
    step(20);
    check("frozen_cnt", 32'(count), 5);
    check("frozen_tick", 32'(tick), 0);
    clr = 1; step(1); clr = 0;
    all_zero("clr1");
    // clr beats start, then start alone
    clr = 1; start = 1; step(1); clr = 0;
    check("clr_start", 32'(state), 0);
    step(1); start = 0;
    check("start2", 32'(state), 1);
    step(3);
    check("tick_after_start2", 32'(tick), 1);
    step(5);
    check("cnt2", 32'(count), 2);
    // pause for 20 cycles at count 2
    pause = 1; step(1);
    check("paused", 32'(state), 2);
    check("qt0", 32'(quiz_ticks), 0);
    step(3);
    check("qt1", 32'(quiz_ticks), 1);
    check("p_cnt", 32'(count), 2);
    step(4);
    check("qt2", 32'(quiz_ticks), 2);
    check("qto_low", 32'(quiz_timeout), 0);
    step(4);
    check("qt3", 32'(quiz_ticks), 3);
    check("qto_pulse", 32'(quiz_timeout), 1);
    step(1);
    check("qto_once", 32'(quiz_timeout), 0);
    step(7);
    check("qt_sat", 32'(quiz_ticks), 3);
    check("qto_norepeat", 32'(quiz_timeout), 0);
    check("p_cnt_hold", 32'(count), 2);
    pause = 0; step(1);
    check("resume", 32'(state), 1);
    check("resume_cnt", 32'(count), 2);
    check("qt_hold_run", 32'(quiz_ticks), 3);
    step(3);
    check("cnt3", 32'(count), 3);
    // second pause: fresh quiz count and timeout
    pause = 1; step(1);
    check("repause_qt0", 32'(quiz_ticks), 0);
    step(11);
    check("repause_qt3", 32'(quiz_ticks), 3);
    check("repause_qto", 32'(quiz_timeout), 1);
    check("repause_cnt", 32'(count), 3);
    // freeze with pause in RUN at count 3
    pause = 0; step(1);
    check("run_again", 32'(state), 1);
    pause = 1; freeze = 1; step(1);
    check("freeze_state", 32'(state), 3);
    step(30);
    check("freeze_cnt", 32'(count), 3);
    check("freeze_state_hold", 32'(state), 3);
    check("freeze_exp", 32'(expired), 0);
    clr = 1; step(1); clr = 0; freeze = 0; pause = 0;
    all_zero("clr2");
    // asynchronous reset while paused
    start = 1; step(1); start = 0;
    step(4);
    check("r_cnt1", 32'(count), 1);
    pause = 1; step(8);
    check("r_paused", 32'(state), 2);
    check("r_qt2", 32'(quiz_ticks), 2);
    #2 Reset = 1;
    #1 all_zero("async_rst");
    pause = 0;
    step(2);
    Reset = 0;
    step(5);
    check("post_rst_idle", 32'(state), 0);
    check("post_rst_cnt", 32'(count), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_timer.md
GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 500000000, board_clk cycles per tick (5 s at 100 MHz); legal range 2..2^29-1.
REQ-002 SHALL have parameter LIMIT, default 8'd96, tick count at which the game time expires.
REQ-003 SHALL have parameter QUIZ_LIMIT, default 4'd12, paused ticks before a quiz timeout.
REQ-004 Port board_clk  in  1  system clock; all state changes occur on its rising edge.
REQ-005 Port Reset  in  1  reset, asynchronous, active-high.
REQ-006 Port clr  in  1  synchronous clear to IDLE; driven by the INI state.
REQ-007 Port start  in  1  single-cycle pulse; begins timing.
REQ-008 Port pause  in  1  level; high while the quiz is active.
REQ-009 Port freeze  in  1  level; high on win or lose.
REQ-010 Port tick  out  1  single-cycle pulse at each prescaler wrap.
REQ-011 Port count  out  8  elapsed ticks, binary; drives the minutes display.
REQ-012 Port quiz_ticks  out  4  ticks elapsed in the current pause.
REQ-013 Port quiz_timeout  out  1  single-cycle pulse when quiz_ticks reaches QUIZ_LIMIT.
REQ-014 Port expired  out  1  level; count has reached LIMIT.
REQ-015 Port state  out  2  FSM state: IDLE=00, RUN=01, PAUSED=10, FROZEN=11.

Function
REQ-016 SHALL implement a 4-state FSM with the encoding given in REQ-015.
REQ-017 Priority, highest first: clr -> IDLE; freeze -> FROZEN (only from RUN or PAUSED); state-specific transitions.
REQ-018 IDLE -> RUN on start=1; IDLE ignores pause and freeze.
REQ-019 RUN -> PAUSED on pause=1; PAUSED -> RUN on pause=0.
REQ-020 RUN -> FROZEN in the cycle after count becomes LIMIT.
REQ-021 FROZEN SHALL be left only by clr or Reset; start is ignored outside IDLE.
REQ-022 Prescaler: 29-bit counter, 0..TICK_CYCLES-1.
  - Runs in RUN and PAUSED; wraps to 0.
  - Held at 0 in IDLE and FROZEN.
  - Zeroed on the IDLE->RUN transition.
  - Pause does not reset it.
REQ-023 tick SHALL be 1 in the cycle the prescaler equals TICK_CYCLES-1 while in RUN or PAUSED, and 0 otherwise.
REQ-024 count SHALL increment by 1 on tick only when the current state is RUN; the transition in that cycle does not matter.
REQ-025 count SHALL saturate at LIMIT.
REQ-026 count SHALL show its new value the cycle after tick (1-cycle latency).
REQ-027 expired = (count == LIMIT), registered; cleared only by clr or Reset.
REQ-028 quiz_ticks SHALL be zeroed on every entry to PAUSED.
REQ-029 quiz_ticks SHALL increment on tick while in PAUSED, saturate at QUIZ_LIMIT, and hold its value in RUN.
REQ-030 quiz_timeout SHALL pulse high for exactly one cycle, the same cycle quiz_ticks first shows QUIZ_LIMIT; it SHALL not repeat while saturated.
REQ-031 clr SHALL zero count, quiz_ticks, expired, prescaler, tick, and quiz_timeout on the next edge.
REQ-032 clr and start in the same cycle: clr wins, state IDLE.
REQ-033 pause and freeze both high in RUN: go to FROZEN.
REQ-034 A tick coinciding with the RUN->PAUSED transition SHALL still increment count.

Reset
REQ-035 Reset SHALL immediately force state=IDLE, count=0, quiz_ticks=0, expired=0, tick=0, quiz_timeout=0, and prescaler=0, independent of board_clk.
REQ-036 Reset asserted mid-RUN or mid-PAUSED SHALL discard all progress; after release, the block waits in IDLE for start.

Verification (TICK_CYCLES=4, LIMIT=5, QUIZ_LIMIT=3)
REQ-037 Start pulse, no pause -> tick every 4 cycles; count 1,2,3,4,5; expired=1 with count=5; state=11 next cycle; no further count changes.
REQ-038 RUN, count=2; pause high for 20 cycles -> count stays 2.
  - quiz_ticks 1,2,3.
  - quiz_timeout one pulse with quiz_ticks=3.
  - Pause low -> state=01, count resumes from 2.
REQ-039 Pause re-asserted after a timeout -> quiz_ticks=0 on entry; a second quiz_timeout occurs after 3 ticks.
REQ-040 freeze=1 and pause=1 in RUN at count=3 -> state=11, count=3 held forever; clr -> state=00, all outputs 0.
REQ-041 clr and start same cycle in IDLE -> state stays 00; start alone the next cycle -> state=01, first tick 4 cycles later.
REQ-042 Reset asserted asynchronously mid-cycle in PAUSED with quiz_ticks=2 -> all outputs 0 before the next edge; state=00 after release.
